// File: rtl/tinyqv_nibble_sequencer_if.sv
// ============================================================================
//  Module      : tinyqv_nibble_sequencer_if
//  Description : Sequencer <-> core/memory signal bundle. The slave modport is
//                the sequencer's view; the master modport is the core side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tinyqv_nibble_sequencer_if;
    logic       i_instr_valid;
    logic       i_is_load;
    logic       i_is_store;
    logic       i_branch;
    logic       i_mem_ready;
    logic [2:0] o_nibble;
    logic       o_core_en;
    logic       o_instr_ack;
    logic       o_mem_req;
    logic       o_mem_we;
    logic       o_pc_inc;
    logic       o_flush;
    logic       o_busy;
    logic       o_bus_err;

    modport slave (
        input  i_instr_valid, i_is_load, i_is_store, i_branch, i_mem_ready,
        output o_nibble, o_core_en, o_instr_ack, o_mem_req, o_mem_we,
        output o_pc_inc, o_flush, o_busy, o_bus_err
    );

    modport master (
        output i_instr_valid, i_is_load, i_is_store, i_branch, i_mem_ready,
        input  o_nibble, o_core_en, o_instr_ack, o_mem_req, o_mem_we,
        input  o_pc_inc, o_flush, o_busy, o_bus_err
    );
endinterface

`default_nettype wire

// File: rtl/tinyqv_nibble_sequencer.sv
// ============================================================================
//  Module      : tinyqv_nibble_sequencer
//  Description : Nibble-serial execution sequencer. Steps the core through
//                eight nibbles per instruction, parks in MEM_WAIT for memory
//                ops, replays eight nibbles for load data, and issues
//                pc_inc/flush/instr_ack at completion.
//                Optional memory-wait timeout: define TINYQV_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyqv_nibble_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    tinyqv_nibble_sequencer_if.slave bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EXEC     = 2'd1;
    localparam logic [1:0] c_MEM_WAIT = 2'd2;
    localparam logic [1:0] c_LOAD     = 2'd3;

    logic [1:0] r_state;
    logic [2:0] r_nibble;

    logic [1:0] w_next_state;
    logic [2:0] w_next_nibble;
    logic       w_core_en;
    logic       w_instr_ack;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_pc_inc;
    logic       w_flush;
    logic       w_complete;
    logic       w_use_branch;
    logic       w_timeout;

    // TIMEOUT_CYCLES must lie in 1..255; anything else is a configuration error.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cfg_invalid
    end

`ifdef TINYQV_SEQ_TIMEOUT_EN
    // The wait counter holds the number of MEM_WAIT cycles already spent
    // without mem_ready, so the abort fires in wait cycle TIMEOUT_CYCLES.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;

    // Count unacknowledged wait cycles; zero whenever outside MEM_WAIT.
    always_ff @(posedge clk) begin
        if (!rstn || r_state != c_MEM_WAIT) begin
            r_wait_cnt <= 8'd0;
        end else if (!bus.i_mem_ready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == c_MEM_WAIT) && !bus.i_mem_ready &&
                       (r_wait_cnt == c_TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state, nibble and pulse decode; completion is shared by all paths.
    always_comb begin
        w_next_state  = r_state;
        w_next_nibble = r_nibble;
        w_core_en     = 1'b0;
        w_instr_ack   = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_pc_inc      = 1'b0;
        w_flush       = 1'b0;
        w_complete    = 1'b0;
        w_use_branch  = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (bus.i_instr_valid) begin
                    w_instr_ack   = 1'b1;
                    w_next_state  = c_EXEC;
                    w_next_nibble = 3'd0;
                end
            end
            c_EXEC: begin
                w_core_en     = 1'b1;
                w_next_nibble = r_nibble + 3'd1;
                if (r_nibble == 3'd7) begin
                    if (bus.i_is_load || bus.i_is_store) begin
                        w_next_state = c_MEM_WAIT;
                    end else begin
                        w_complete   = 1'b1;
                        w_use_branch = 1'b1;
                    end
                end
            end
            c_MEM_WAIT: begin
                w_mem_req = 1'b1;
                // A load takes priority when both qualifiers are set.
                w_mem_we  = bus.i_is_store && !bus.i_is_load;
                if (bus.i_mem_ready) begin
                    if (bus.i_is_load) begin
                        w_next_state  = c_LOAD;
                        w_next_nibble = 3'd0;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state  = c_IDLE;
                    w_next_nibble = 3'd0;
                end
            end
            c_LOAD: begin
                w_core_en     = 1'b1;
                w_next_nibble = r_nibble + 3'd1;
                if (r_nibble == 3'd7) begin
                    w_complete = 1'b1;
                end
            end
            default: begin
                w_next_state  = c_IDLE;
                w_next_nibble = 3'd0;
            end
        endcase

        // Memory completions always advance the PC; only ALU/branch ops flush.
        if (w_complete) begin
            w_flush       = w_use_branch && bus.i_branch;
            w_pc_inc      = !(w_use_branch && bus.i_branch);
            w_next_nibble = 3'd0;
            if (bus.i_instr_valid) begin
                w_instr_ack  = 1'b1;
                w_next_state = c_EXEC;
            end else begin
                w_next_state = c_IDLE;
            end
        end
    end

    // State and nibble registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_IDLE;
            r_nibble <= 3'd0;
        end else begin
            r_state  <= w_next_state;
            r_nibble <= w_next_nibble;
        end
    end

    // Outputs are forced low while reset is asserted so instr_valid is ignored.
    assign bus.o_nibble    = rstn ? r_nibble : 3'd0;
    assign bus.o_core_en   = rstn && w_core_en;
    assign bus.o_instr_ack = rstn && w_instr_ack;
    assign bus.o_mem_req   = rstn && w_mem_req;
    assign bus.o_mem_we    = rstn && w_mem_we;
    assign bus.o_pc_inc    = rstn && w_pc_inc;
    assign bus.o_flush     = rstn && w_flush;
    assign bus.o_busy      = rstn && (r_state != c_IDLE);
    assign bus.o_bus_err   = rstn && w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_tinyqv_nibble_sequencer.sv
// ============================================================================
//  Module      : tb_tinyqv_nibble_sequencer
//  Description : Directed bench for tinyqv_nibble_sequencer. Inputs change
//                just after a rising edge; outputs are compared mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinyqv_nibble_sequencer;

`ifdef TINYQV_SEQ_TIMEOUT_EN
    localparam int unsigned c_TIMEOUT = 4;
`else
    localparam int unsigned c_TIMEOUT = 255;
`endif

    logic clk;
    logic rstn;
    int   passed;
    int   total;

    tinyqv_nibble_sequencer_if bus ();

    tinyqv_nibble_sequencer #(
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Compare the full output vector against a hand-computed expectation.
    task automatic ck(input string tag, input logic [2:0] nib, input logic en,
                      input logic ack, input logic req, input logic we,
                      input logic pc, input logic fl, input logic bz,
                      input logic be);
        logic [10:0] w_exp;
        logic [10:0] w_obs;
        #1;
        w_exp = {nib, en, ack, req, we, pc, fl, bz, be};
        w_obs = {bus.o_nibble, bus.o_core_en, bus.o_instr_ack, bus.o_mem_req,
                 bus.o_mem_we, bus.o_pc_inc, bus.o_flush, bus.o_busy,
                 bus.o_bus_err};
        total++;
        assert (w_obs === w_exp) passed++;
        else $error("FAIL %s: observed %b expected %b (nib,en,ack,req,we,pc,fl,busy,err)",
                    tag, w_obs, w_exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rstn   = 1'b0;
        bus.i_instr_valid = 1'b1;
        bus.i_is_load     = 1'b0;
        bus.i_is_store    = 1'b0;
        bus.i_branch      = 1'b0;
        bus.i_mem_ready   = 1'b0;

        // Reset with instr_valid high: nothing may respond.
        nxt();
        ck("rst_hold", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        rstn = 1'b1;
        bus.i_instr_valid = 1'b0;
        bus.i_mem_ready   = 1'b1;
        ck("rst_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_mem_ready = 1'b0;

        // ALU op: ack, 8 execute nibbles, pc_inc at nibble 7, back to idle.
        bus.i_instr_valid = 1'b1;
        ck("alu_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ck("alu_exec", 3'(k), 1, 0, 0, 0, (k == 7), 0, 1, 0);
            nxt();
        end
        ck("alu_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // Back-to-back: taken branch flushes and acks the next instruction.
        bus.i_instr_valid = 1'b1;
        bus.i_branch      = 1'b1;
        ck("b2b_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        for (int k = 0; k < 8; k++) begin
            ck("b2b_first", 3'(k), 1, (k == 7), 0, 0, 0, (k == 7), 1, 0);
            nxt();
        end
        bus.i_instr_valid = 1'b0;
        bus.i_branch      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ck("b2b_second", 3'(k), 1, 0, 0, 0, (k == 7), 0, 1, 0);
            nxt();
        end
        ck("b2b_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // Load: stray mem_ready during execute ignored, 5 idle waits, then ready.
        bus.i_instr_valid = 1'b1;
        bus.i_is_load     = 1'b1;
        ck("ld_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.i_mem_ready = (k == 2);
            ck("ld_exec", 3'(k), 1, 0, 0, 0, 0, 0, 1, 0);
            nxt();
        end
        bus.i_mem_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            ck("ld_wait", 3'd0, 0, 0, 1, 0, 0, 0, 1, 0);
            nxt();
        end
        bus.i_mem_ready = 1'b1;
        ck("ld_ready", 3'd0, 0, 0, 1, 0, 0, 0, 1, 0);
        nxt();
        bus.i_mem_ready = 1'b0;
        bus.i_branch    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ck("ld_data", 3'(k), 1, 0, 0, 0, (k == 7), 0, 1, 0);
            nxt();
        end
        bus.i_is_load = 1'b0;
        bus.i_branch  = 1'b0;
        ck("ld_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // Load and store both set: behaves as a load, mem_we stays low.
        bus.i_instr_valid = 1'b1;
        bus.i_is_load     = 1'b1;
        bus.i_is_store    = 1'b1;
        ck("both_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) nxt();
        ck("both_wait", 3'd0, 0, 0, 1, 0, 0, 0, 1, 0);
        nxt();
        bus.i_mem_ready = 1'b1;
        ck("both_ready", 3'd0, 0, 0, 1, 0, 0, 0, 1, 0);
        nxt();
        bus.i_mem_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ck("both_load", 3'(k), 1, 0, 0, 0, (k == 7), 0, 1, 0);
            nxt();
        end
        bus.i_is_load  = 1'b0;
        bus.i_is_store = 1'b0;
        ck("both_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // Store with immediate ready: pc_inc in the wait cycle, branch ignored.
        bus.i_instr_valid = 1'b1;
        bus.i_is_store    = 1'b1;
        bus.i_branch      = 1'b1;
        ck("st_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ck("st_exec", 3'(k), 1, 0, 0, 0, 0, 0, 1, 0);
            nxt();
        end
        bus.i_mem_ready = 1'b1;
        ck("st_ready", 3'd0, 0, 0, 1, 1, 1, 0, 1, 0);
        nxt();
        bus.i_mem_ready = 1'b0;
        bus.i_is_store  = 1'b0;
        bus.i_branch    = 1'b0;
        ck("st_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // Store left waiting: timeout build aborts, default build waits on.
        bus.i_instr_valid = 1'b1;
        bus.i_is_store    = 1'b1;
        ck("to_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 8; k++) nxt();
`ifdef TINYQV_SEQ_TIMEOUT_EN
        for (int w = 1; w <= 4; w++) begin
            ck("to_wait", 3'd0, 0, 0, 1, 1, 0, 0, 1, (w == 4));
            nxt();
        end
`else
        for (int w = 0; w < 20; w++) begin
            ck("to_wait", 3'd0, 0, 0, 1, 1, 0, 0, 1, 0);
            nxt();
        end
        bus.i_mem_ready = 1'b1;
        ck("to_ready", 3'd0, 0, 0, 1, 1, 1, 0, 1, 0);
        nxt();
        bus.i_mem_ready = 1'b0;
`endif
        ck("to_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.i_is_store = 1'b0;
        nxt();

        // Reset asserted at execute nibble 4.
        bus.i_instr_valid = 1'b1;
        ck("rm_ack", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        for (int k = 0; k < 4; k++) nxt();
        ck("rm_nib4", 3'd4, 1, 0, 0, 0, 0, 0, 1, 0);
        rstn = 1'b0;
        bus.i_instr_valid = 1'b1;
        ck("rm_assert", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        rstn = 1'b1;
        bus.i_instr_valid = 1'b0;
        ck("rm_idle", 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b1;
        ck("rm_restart", 3'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        nxt();
        bus.i_instr_valid = 1'b0;
        ck("rm_exec0", 3'd0, 1, 0, 0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tinyqv_nibble_sequencer.md
TINYQV_NIBBLE_SEQUENCER -- requirements
Module: tinyqv_nibble_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, memory-wait cycles before abort (only used with TINYQV_SEQ_TIMEOUT_EN; range 1-255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 instr_valid  input  1  decoded instruction available to the core.
REQ-005 is_load  input  1  current instruction is a load.
REQ-006 is_store  input  1  current instruction is a store.
REQ-007 branch  input  1  core branch-taken indication, sampled at last nibble of execute.
REQ-008 mem_ready  input  1  memory acknowledge: store accepted, or load data available.
REQ-009 nibble  output  3  nibble index driven to the core (bit offset = nibble*4).
REQ-010 core_en  output  1  core clock-enable; the core advances one nibble per cycle when high.
REQ-011 instr_ack  output  1  one-cycle pulse consuming the current instruction.
REQ-012 mem_req  output  1  memory request, held until mem_ready.
REQ-013 mem_we  output  1  write qualifier, valid while mem_req high.
REQ-014 pc_inc  output  1  one-cycle pulse: advance PC sequentially.
REQ-015 flush  output  1  one-cycle pulse: branch taken, discard prefetch.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 bus_err  output  1  one-cycle pulse on memory timeout (tied 0 without TINYQV_SEQ_TIMEOUT_EN).

Function
REQ-018 Four states SHALL exist: IDLE, EXEC, MEM_WAIT, LOAD.
REQ-019 IDLE: nibble=0, core_en=0; on instr_valid, instr_ack=1 in the same cycle, next state EXEC.
REQ-020 EXEC: core_en=1, nibble increments by 1 each cycle from 0 to 7 (8 cycles, 3-bit wrap 7->0).
REQ-021 EXEC at nibble 7 with is_load or is_store: next state MEM_WAIT, nibble wraps to 0.
REQ-022 EXEC at nibble 7 with neither: instruction completes in that cycle.
REQ-023 Completion: pc_inc=1 if branch=0, else flush=1 (never both); if instr_valid also high, instr_ack=1 and next state EXEC at nibble 0 (zero-bubble back-to-back), else IDLE.
REQ-024 MEM_WAIT: core_en=0, nibble=0, mem_req=1, mem_we=is_store and !is_load; is_load and is_store both high SHALL be treated as load.
REQ-025 MEM_WAIT with mem_ready and store: completion per REQ-023 in that cycle; mem_req low next cycle.
REQ-026 MEM_WAIT with mem_ready and load: next state LOAD; mem_req low next cycle.
REQ-027 LOAD: core_en=1, nibble 0..7 over 8 cycles; completion per REQ-023 at nibble 7.
REQ-028 branch SHALL be ignored for load/store completions (pc_inc always).
REQ-029 mem_ready outside MEM_WAIT SHALL be ignored.
REQ-030 Execute latency: non-memory instruction = 8 cycles from instr_ack to completion pulse.

Reset
REQ-031 rstn=0 at a rising edge SHALL force IDLE, nibble=0, timeout counter=0, from any state including mid-EXEC/MEM_WAIT/LOAD.
REQ-032 Reset values: core_en=0, instr_ack=0, mem_req=0, mem_we=0, pc_inc=0, flush=0, busy=0, bus_err=0; instr_valid ignored while rstn=0.

Configuration
REQ-033 Macro TINYQV_SEQ_TIMEOUT_EN defined: 8-bit counter clears on MEM_WAIT entry, increments each MEM_WAIT cycle without mem_ready.
REQ-034 With macro: counter reaching TIMEOUT_CYCLES without mem_ready SHALL pulse bus_err, drop mem_req next cycle, go IDLE without pc_inc/flush; mem_ready in the same cycle wins over timeout.
REQ-035 Without macro: no counter, bus_err tied 0, MEM_WAIT waits indefinitely.

Verification
REQ-036 ALU op: instr_valid=1 one cycle from IDLE -> instr_ack same cycle, core_en 8 cycles with nibble 0..7, pc_inc at nibble 7, then IDLE.
REQ-037 Back-to-back: instr_valid held, branch=1 on first -> flush at first nibble 7, instr_ack same cycle, second EXEC starts at nibble 0 next cycle.
REQ-038 Load: is_load=1, mem_ready after 5 MEM_WAIT cycles -> mem_req 5+1 cycles, mem_we=0, 8 LOAD cycles, pc_inc; total 8+6+8 cycles.
REQ-039 Store with is_load=is_store=1 -> mem_we=0 (load priority); store-only mem_ready immediate -> pc_inc in MEM_WAIT cycle.
REQ-040 Reset at EXEC nibble 4 -> next cycle IDLE, nibble=0, all outputs 0.
REQ-041 With TINYQV_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never -> bus_err pulse on 4th wait cycle, IDLE, no pc_inc.
